// File: rtl/jam_pkg.sv
// Shared widths, table geometry and state encoding for the cost table server.
package jam_pkg;
    localparam int COST_W    = 7;
    localparam int SUM_W     = 10;
    localparam int CNT_W     = 4;
    localparam int TBL_DIM   = 8;
    localparam int IDX_W     = 3;
    localparam int ADDR_W    = 2 * IDX_W;
    localparam int TBL_DEPTH = TBL_DIM * TBL_DIM;
    localparam int CYC_W     = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Row-major table address: worker selects the row, job the column.
    function automatic logic [ADDR_W-1:0] tbl_addr(input logic [IDX_W-1:0] w,
                                                   input logic [IDX_W-1:0] j);
        return {w, j};
    endfunction
endpackage

// File: rtl/cost_ram.sv
// 64 x 7 cost register file: synchronous write, asynchronous read.
module cost_ram
    import jam_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COST_W-1:0] rdata
);
    // Contents are intentionally not reset; readers gate stale data.
    logic [COST_W-1:0] mem_q [TBL_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/cost_table_server.sv
// Loads an 8x8 cost table, serves it to a job-assignment machine and grades
// the machine's result against expected values, with a SERVE-cycle timeout.
//
// state    | meaning
// ST_IDLE  | waiting for start, machine held in reset
// ST_LOAD  | accepting 64 cost words, machine held in reset
// ST_SERVE | machine running, table lookups live, cycles counting
// ST_DONE  | result latched, flags held until next start
module cost_table_server
    import jam_pkg::*;
#(
    parameter logic [CYC_W-1:0] TIMEOUT = 20'd1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [SUM_W-1:0]  exp_cost,
    input  logic [CNT_W-1:0]  exp_match,
    input  logic              ld_valid,
    input  logic [COST_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              jam_rst,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [SUM_W-1:0]  MinCost,
    input  logic [CNT_W-1:0]  MatchCount,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycles
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [SUM_W-1:0]  exp_cost_q, exp_cost_d;
    logic [CNT_W-1:0]  exp_match_q, exp_match_d;

    logic              ram_we;
    logic [COST_W-1:0] ram_rdata;

    cost_ram u_cost_ram (
        .clk   (CLK),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (ld_data),
        .raddr (tbl_addr(W, J)),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            exp_cost_q  <= '0;
            exp_match_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            exp_cost_q  <= exp_cost_d;
            exp_match_q <= exp_match_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cycles_d    = cycles_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        exp_cost_d  = exp_cost_q;
        exp_match_d = exp_match_q;
        ram_we      = 1'b0;
        ld_ready    = 1'b0;
        jam_rst     = 1'b0;
        Cost        = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                jam_rst = (state_q == ST_IDLE);
                if (start) begin
                    state_d     = ST_LOAD;
                    addr_d      = '0;
                    cycles_d    = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    exp_cost_d  = exp_cost;
                    exp_match_d = exp_match;
                end
            end
            ST_LOAD: begin
                jam_rst  = 1'b1;
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == '1) begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                Cost = ram_rdata;
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 1'b1;
                end
                // A result arriving on the timeout cycle still counts.
                if (Valid) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    pass_d    = (MinCost == exp_cost_q) && (MatchCount == exp_match_q);
                    timeout_d = 1'b0;
                end else if (cycles_q == (TIMEOUT - 1'b1)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done    = done_q;
    assign pass    = pass_q;
    assign timeout = timeout_q;
    assign cycles  = cycles_q;
endmodule

// File: tb/tb_cost_table_server.sv
// Randomized self-checking bench for cost_table_server against a table/counter model.
module tb_cost_table_server;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  exp_cost = '0;
    logic [3:0]  exp_match = '0;
    logic        ld_valid = 1'b0;
    logic [6:0]  ld_data = '0;
    logic        ld_ready;
    logic        jam_rst;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic        Valid = 1'b0;
    logic [9:0]  MinCost = '0;
    logic [3:0]  MatchCount = '0;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [19:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    int mdl_tbl [8][8];
    int mdl_cycles;
    int mdl_exp_cost;
    int mdl_exp_match;

    cost_table_server #(.TIMEOUT(20'd100)) dut (
        .CLK(CLK), .RST(RST), .start(start), .exp_cost(exp_cost), .exp_match(exp_match),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .jam_rst(jam_rst),
        .W(W), .J(J), .Cost(Cost), .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .done(done), .pass(pass), .timeout(timeout), .cycles(cycles)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_test(input int ec, input int em);
        start = 1'b1;
        exp_cost = 10'(ec);
        exp_match = 4'(em);
        mdl_exp_cost = ec;
        mdl_exp_match = em;
        tick();
        start = 1'b0;
        exp_cost = 10'($urandom);
        exp_match = 4'($urandom);
        n_tests++;
        if (ld_ready !== 1'b1 || jam_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL start_enters_load: ld_ready=%0b jam_rst=%0b expected 1 1", ld_ready, jam_rst);
        end
        n_tests++;
        if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0 || cycles !== 20'd0) begin
            n_fail++;
            $display("FAIL start_clears: done=%0b pass=%0b timeout=%0b cycles=%0d expected 0 0 0 0",
                     done, pass, timeout, cycles);
        end
    endtask

    // mode 0: table[w][j] = 8w+j, mode 1: random. Negative indices disable an option.
    task automatic load_table(input int mode, input int gap_at, input int abort_at, input int start_at);
        int val;
        for (int i = 0; i < 64; i++) begin
            if (i == abort_at) begin
                ld_valid = 1'b0;
                RST = 1'b1;
                #1;
                n_tests++;
                if (ld_ready !== 1'b0 || jam_rst !== 1'b1 || Cost !== 7'd0 || cycles !== 20'd0) begin
                    n_fail++;
                    $display("FAIL reset_midload: ld_ready=%0b jam_rst=%0b Cost=%0d cycles=%0d expected 0 1 0 0",
                             ld_ready, jam_rst, Cost, cycles);
                end
                #2;
                RST = 1'b0;
                tick();
                return;
            end
            if (i == gap_at) begin
                repeat (3) begin
                    ld_valid = 1'b0;
                    ld_data = 7'($urandom);
                    tick();
                end
                n_tests++;
                if (ld_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_holds_load: ld_ready=%0b expected 1", ld_ready);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                ld_data = 7'($urandom);
                tick();
            end
            val = (mode == 0) ? i : int'($urandom_range(0, 127));
            mdl_tbl[i / 8][i % 8] = val;
            ld_valid = 1'b1;
            ld_data = 7'(val);
            Valid = 1'($urandom);
            MinCost = 10'(mdl_exp_cost);
            MatchCount = 4'(mdl_exp_match);
            W = 3'($urandom);
            J = 3'($urandom);
            start = (i == start_at);
            if (i == 5) begin
                #1;
                n_tests++;
                if (Cost !== 7'd0) begin
                    n_fail++;
                    $display("FAIL cost_gated_in_load: got %0d expected 0", Cost);
                end
            end
            tick();
            start = 1'b0;
        end
        ld_valid = 1'b0;
        Valid = 1'b0;
        mdl_cycles = 0;
        n_tests++;
        if (ld_ready !== 1'b0 || jam_rst !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_entry: ld_ready=%0b jam_rst=%0b done=%0b expected 0 0 0", ld_ready, jam_rst, done);
        end
    endtask

    task automatic serve_lookups(input int n);
        for (int k = 0; k < n; k++) begin
            W = 3'($urandom);
            J = 3'($urandom);
            #1;
            n_tests++;
            if (Cost !== 7'(mdl_tbl[W][J])) begin
                n_fail++;
                $display("FAIL lookup W=%0d J=%0d: got %0d expected %0d", W, J, Cost, mdl_tbl[W][J]);
            end
            tick();
            mdl_cycles++;
        end
    endtask

    task automatic finish_valid(input int mc, input int mm);
        logic exp_pass;
        exp_pass = (mc == mdl_exp_cost) && (mm == mdl_exp_match);
        Valid = 1'b1;
        MinCost = 10'(mc);
        MatchCount = 4'(mm);
        tick();
        mdl_cycles++;
        n_tests++;
        if (done !== 1'b1 || pass !== exp_pass || timeout !== 1'b0 || cycles !== 20'(mdl_cycles)) begin
            n_fail++;
            $display("FAIL result: done=%0b pass=%0b timeout=%0b cycles=%0d expected 1 %0b 0 %0d",
                     done, pass, timeout, cycles, exp_pass, mdl_cycles);
        end
        n_tests++;
        if (jam_rst !== 1'b0 || Cost !== 7'd0 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_outputs: jam_rst=%0b Cost=%0d ld_ready=%0b expected 0 0 0", jam_rst, Cost, ld_ready);
        end
        MinCost = ~MinCost;
        tick();
        Valid = 1'b0;
        n_tests++;
        if (done !== 1'b1 || pass !== exp_pass || cycles !== 20'(mdl_cycles)) begin
            n_fail++;
            $display("FAIL done_holds: done=%0b pass=%0b cycles=%0d expected 1 %0b %0d",
                     done, pass, cycles, exp_pass, mdl_cycles);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (ld_ready !== 1'b0 || jam_rst !== 1'b1 || Cost !== 7'd0 || done !== 1'b0 ||
            pass !== 1'b0 || timeout !== 1'b0 || cycles !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_state: ld_ready=%0b jam_rst=%0b Cost=%0d done=%0b pass=%0b timeout=%0b cycles=%0d",
                     ld_ready, jam_rst, Cost, done, pass, timeout, cycles);
        end
        RST = 1'b0;
        tick();
        n_tests++;
        if (jam_rst !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: jam_rst=%0b ld_ready=%0b expected 1 0", jam_rst, ld_ready);
        end
    endtask

    task automatic test_cost_lookup();
        start_test(300, 2);
        load_table(0, 10, -1, -1);
        W = 3'd3;
        J = 3'd5;
        #1;
        n_tests++;
        if (Cost !== 7'd29) begin
            n_fail++;
            $display("FAIL cost_3_5: got %0d expected 29", Cost);
        end
        W = 3'd7;
        J = 3'd7;
        #1;
        n_tests++;
        if (Cost !== 7'd63) begin
            n_fail++;
            $display("FAIL cost_7_7: got %0d expected 63", Cost);
        end
        tick();
        mdl_cycles++;
        serve_lookups(12);
        finish_valid(300, 2);
    endtask

    task automatic test_pass_fail();
        int ec, em, mc, mm;
        for (int it = 0; it < 6; it++) begin
            case (it)
                0: begin ec = 300; em = 2; mc = 300; mm = 2; end
                1: begin ec = 300; em = 2; mc = 300; mm = 3; end
                2: begin ec = 1023; em = 15; mc = 1023; mm = 15; end
                3: begin ec = 1023; em = 15; mc = 511; mm = 15; end
                default: begin
                    ec = int'($urandom_range(0, 1023));
                    em = int'($urandom_range(0, 15));
                    mc = ($urandom_range(0, 1) == 1) ? ec : (ec ^ (1 << $urandom_range(0, 9)));
                    mm = em;
                end
            endcase
            start_test(ec, em);
            load_table(1, -1, -1, -1);
            serve_lookups(int'($urandom_range(1, 8)));
            finish_valid(mc, mm);
        end
    endtask

    task automatic test_timeout();
        int k_done;
        k_done = 0;
        start_test(int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)));
        load_table(1, -1, -1, -1);
        Valid = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (done === 1'b1) begin
                k_done = k;
                break;
            end
        end
        n_tests++;
        if (k_done !== 100) begin
            n_fail++;
            $display("FAIL timeout_cycle: done after %0d serve cycles expected 100", k_done);
        end
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || cycles !== 20'd100) begin
            n_fail++;
            $display("FAIL timeout_flags: done=%0b timeout=%0b pass=%0b cycles=%0d expected 1 1 0 100",
                     done, timeout, pass, cycles);
        end
        Valid = 1'b1;
        MinCost = 10'(mdl_exp_cost);
        MatchCount = 4'(mdl_exp_match);
        repeat (3) tick();
        Valid = 1'b0;
        n_tests++;
        if (timeout !== 1'b1 || pass !== 1'b0 || cycles !== 20'd100) begin
            n_fail++;
            $display("FAIL valid_ignored_in_done: timeout=%0b pass=%0b cycles=%0d expected 1 0 100",
                     timeout, pass, cycles);
        end
    endtask

    task automatic test_valid_wins();
        start_test(int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)));
        load_table(1, -1, -1, -1);
        serve_lookups(99);
        n_tests++;
        if (done !== 1'b0 || cycles !== 20'd99) begin
            n_fail++;
            $display("FAIL before_timeout: done=%0b cycles=%0d expected 0 99", done, cycles);
        end
        finish_valid(mdl_exp_cost, mdl_exp_match);
    endtask

    task automatic test_reset_midload();
        start_test(77, 9);
        load_table(1, -1, 30, -1);
        start_test(123, 4);
        load_table(1, -1, -1, 20);
        serve_lookups(3);
        start = 1'b1;
        exp_cost = 10'd5;
        tick();
        start = 1'b0;
        mdl_cycles++;
        n_tests++;
        if (ld_ready !== 1'b0 || jam_rst !== 1'b0 || cycles !== 20'(mdl_cycles)) begin
            n_fail++;
            $display("FAIL start_ignored_in_serve: ld_ready=%0b jam_rst=%0b cycles=%0d expected 0 0 %0d",
                     ld_ready, jam_rst, cycles, mdl_cycles);
        end
        W = 3'd0;
        J = 3'd0;
        #1;
        n_tests++;
        if (Cost !== 7'(mdl_tbl[0][0])) begin
            n_fail++;
            $display("FAIL restart_addr0: got %0d expected %0d", Cost, mdl_tbl[0][0]);
        end
        tick();
        mdl_cycles++;
        finish_valid(123, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mdl_exp_cost = 0;
        mdl_exp_match = 0;
        mdl_cycles = 0;
        test_reset();
        test_cost_lookup();
        test_pass_fail();
        test_timeout();
        test_valid_wins();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
